// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the rv32i pipeline hazard/control unit.
//   fwd_sel_t    : forwarding mux select per source operand
//   ctrl_state_t : RUN/DRAIN/HALT control state
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding select for one source operand (purely combinational).
//   rs_i/use_i           : source register and whether it is read
//   e/m/w_rd_i, _wb_i    : downstream destination regs and write enables
//   sel_o                : first matching stage E>M>W, else register file
module pipe_hazard_ctrl_fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FWD_DEPTH = 3
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    input  logic [REG_AW-1:0] e_rd_i,
    input  logic [REG_AW-1:0] m_rd_i,
    input  logic [REG_AW-1:0] w_rd_i,
    input  logic              e_wb_i,
    input  logic              m_wb_i,
    input  logic              w_wb_i,
    output fwd_sel_t          sel_o
);

    // x0 is hardwired zero, so it never forwards; stages beyond FWD_DEPTH are ignored.
    always_comb begin
        sel_o = FWD_RF;
        if (use_i && (rs_i != '0)) begin
            if ((FWD_DEPTH >= 1) && e_wb_i && (rs_i == e_rd_i)) begin
                sel_o = FWD_E;
            end else if ((FWD_DEPTH >= 2) && m_wb_i && (rs_i == m_rd_i)) begin
                sel_o = FWD_M;
            end else if ((FWD_DEPTH >= 3) && w_wb_i && (rs_i == w_rd_i)) begin
                sel_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/control unit for the 5-stage rv32i pipeline.
//   Inputs : D sources, E/M/W destinations, load/redirect/memory handshake,
//            W fault + PC, debug halt/resume.
//   Outputs: fwd_a/fwd_b selects, stall_f/d/e/m, bubble_d/e/w,
//            halted, fault_pc, fault_valid.
// Optional: define PIPE_PERF_CNT_EN to add 64-bit cyc_cnt/stall_cnt/flush_cnt.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_DEPTH = 3,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic [REG_AW-1:0] e_rd,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              e_wb,
    input  logic              m_wb,
    input  logic              w_wb,
    input  logic              e_load,
    input  logic              e_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              w_fault,
    input  logic [XLEN-1:0]   w_pc,
    input  logic              halt_req,
    input  logic              resume_req,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              bubble_d,
    output logic              bubble_e,
    output logic              bubble_w,
    output logic              halted,
    output logic [XLEN-1:0]   fault_pc,
`ifdef PIPE_PERF_CNT_EN
    output logic [63:0]       cyc_cnt,
    output logic [63:0]       stall_cnt,
    output logic [63:0]       flush_cnt,
`endif
    output logic              fault_valid
);

    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    ctrl_state_t       state_q;
    logic [CNT_W-1:0]  drain_cnt_q;
    logic [XLEN-1:0]   fault_pc_q;
    logic              fault_valid_q;

    fwd_sel_t          sel_a;
    fwd_sel_t          sel_b;
    logic              mem_wait;
    logic              load_use;

    pipe_hazard_ctrl_fwd_select #(.FWD_DEPTH(FWD_DEPTH)) u_fwd_a (
        .rs_i(d_rs1), .use_i(d_use1),
        .e_rd_i(e_rd), .m_rd_i(m_rd), .w_rd_i(w_rd),
        .e_wb_i(e_wb), .m_wb_i(m_wb), .w_wb_i(w_wb),
        .sel_o(sel_a)
    );

    pipe_hazard_ctrl_fwd_select #(.FWD_DEPTH(FWD_DEPTH)) u_fwd_b (
        .rs_i(d_rs2), .use_i(d_use2),
        .e_rd_i(e_rd), .m_rd_i(m_rd), .w_rd_i(w_rd),
        .e_wb_i(e_wb), .m_wb_i(m_wb), .w_wb_i(w_wb),
        .sel_o(sel_b)
    );

    assign mem_wait = mem_req && !mem_ready;
    // An E-stage match always wins the search, so an E select means the load result is needed now.
    assign load_use = e_load && ((sel_a == FWD_E) || (sel_b == FWD_E));

    // Outputs held at zero while reset is asserted.
    assign fwd_a = reset_n ? sel_a : FWD_RF;
    assign fwd_b = reset_n ? sel_b : FWD_RF;

    // Stall/bubble resolution: HALT > mem wait > redirect > load-use > drain fetch gating.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        bubble_d = 1'b0;
        bubble_e = 1'b0;
        bubble_w = 1'b0;
        if (reset_n) begin
            if (state_q == ST_HALT) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                stall_m  = 1'b1;
                bubble_w = 1'b1;
            end else begin
                if (state_q == ST_DRAIN) begin
                    stall_f  = 1'b1;
                    bubble_d = 1'b1;
                end
                if (mem_wait) begin
                    // Everything up to M holds; a held redirect is applied once ready rises.
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    stall_m  = 1'b1;
                    bubble_d = 1'b0;
                    bubble_w = 1'b1;
                end else if (e_redirect) begin
                    bubble_d = 1'b1;
                    bubble_e = 1'b1;
                end else if (load_use && (state_q == ST_RUN)) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    bubble_e = 1'b1;
                end
            end
        end
    end

    // RUN/DRAIN/HALT control with first-fault capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            fault_pc_q    <= '0;
            fault_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_fault) begin
                        state_q <= ST_HALT;
                        if (!fault_valid_q) begin
                            fault_pc_q    <= w_pc;
                            fault_valid_q <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_fault) begin
                        state_q <= ST_HALT;
                        if (!fault_valid_q) begin
                            fault_pc_q    <= w_pc;
                            fault_valid_q <= 1'b1;
                        end
                    end else if (!mem_wait) begin
                        if (drain_cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                            state_q <= ST_HALT;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    // A captured fault can only be cleared by reset.
                    if (resume_req && !fault_valid_q) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign fault_pc    = fault_pc_q;
    assign fault_valid = fault_valid_q;

`ifdef PIPE_PERF_CNT_EN
    logic [63:0] cyc_cnt_q;
    logic [63:0] stall_cnt_q;
    logic [63:0] flush_cnt_q;
    logic        flush_hit;

    assign flush_hit = (state_q != ST_HALT) && !mem_wait && e_redirect;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q != ST_HALT)               cyc_cnt_q   <= cyc_cnt_q + 64'd1;
            if (stall_d && (state_q == ST_RUN))   stall_cnt_q <= stall_cnt_q + 64'd1;
            if (flush_hit)                        flush_cnt_q <= flush_cnt_q + 64'd1;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, redirect,
// memory wait, debug drain/halt/resume and fault capture.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [4:0]  d_rs1, d_rs2, e_rd, m_rd, w_rd;
    logic        d_use1, d_use2, e_wb, m_wb, w_wb;
    logic        e_load, e_redirect, mem_req, mem_ready, w_fault;
    logic [31:0] w_pc;
    logic        halt_req, resume_req;
    fwd_sel_t    fwd_a, fwd_b;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        bubble_d, bubble_e, bubble_w;
    logic        halted, fault_valid;
    logic [31:0] fault_pc;
`ifdef PIPE_PERF_CNT_EN
    logic [63:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
        .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
        .e_wb(e_wb), .m_wb(m_wb), .w_wb(w_wb),
        .e_load(e_load), .e_redirect(e_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .w_fault(w_fault), .w_pc(w_pc),
        .halt_req(halt_req), .resume_req(resume_req),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_d(bubble_d), .bubble_e(bubble_e), .bubble_w(bubble_w),
        .halted(halted), .fault_pc(fault_pc),
`ifdef PIPE_PERF_CNT_EN
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .fault_valid(fault_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {stall_f, stall_d, stall_e, stall_m, bubble_d, bubble_e, bubble_w}
    function automatic logic [6:0] ctl();
        return {stall_f, stall_d, stall_e, stall_m, bubble_d, bubble_e, bubble_w};
    endfunction

    task automatic clear();
        d_rs1 = '0; d_rs2 = '0; d_use1 = 1'b0; d_use2 = 1'b0;
        e_rd = '0; m_rd = '0; w_rd = '0; e_wb = 1'b0; m_wb = 1'b0; w_wb = 1'b0;
        e_load = 1'b0; e_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        w_fault = 1'b0; w_pc = '0; halt_req = 1'b0; resume_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear();
        reset_n = 1'b0;
        // Inputs that would cause load-use + mem wait; outputs must stay 0 in reset.
        e_load = 1'b1; e_rd = 5'd6; e_wb = 1'b1; d_rs2 = 5'd6; d_use2 = 1'b1; mem_req = 1'b1;
        #12;
        chk("rst_ctl",    64'(ctl()), 64'h0);
        chk("rst_fwd_b",  64'(fwd_b), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fpc",    64'(fault_pc), 64'h0);
        chk("rst_fvalid", 64'(fault_valid), 64'd0);
        clear();
        tick();
        reset_n = 1'b1;
        tick();

        // 1: ALU forwarding from E, and x0 never forwarded
        e_rd = 5'd5; e_wb = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1; #1;
        chk("fwdE_a",   64'(fwd_a), 64'd1);
        chk("fwdE_ctl", 64'(ctl()), 64'h0);
        e_rd = 5'd0; d_rs1 = 5'd0; #1;
        chk("x0_a", 64'(fwd_a), 64'd0);
        // priority E > M > W, use gating, rs2 path
        d_rs1 = 5'd7; e_rd = 5'd7; m_rd = 5'd7; w_rd = 5'd7; m_wb = 1'b1; w_wb = 1'b1; #1;
        chk("prio_E", 64'(fwd_a), 64'd1);
        e_wb = 1'b0; #1;
        chk("prio_M", 64'(fwd_a), 64'd2);
        m_wb = 1'b0; #1;
        chk("prio_W", 64'(fwd_a), 64'd3);
        d_use1 = 1'b0; #1;
        chk("nouse_a", 64'(fwd_a), 64'd0);
        d_rs2 = 5'd7; d_use2 = 1'b1; #1;
        chk("fwdW_b", 64'(fwd_b), 64'd3);
        clear();

        // 2: load-use on rs2 stalls one cycle, then forwards from M
        e_load = 1'b1; e_rd = 5'd6; e_wb = 1'b1; d_rs2 = 5'd6; d_use2 = 1'b1; #1;
        chk("lu_ctl",   64'(ctl()), 64'b1100010);
        chk("lu_fwd_b", 64'(fwd_b), 64'd1);
        tick();
        clear();
        m_rd = 5'd6; m_wb = 1'b1; d_rs2 = 5'd6; d_use2 = 1'b1; #1;
        chk("lu_next_ctl", 64'(ctl()), 64'h0);
        chk("lu_next_fwd", 64'(fwd_b), 64'd2);
        clear();

        // 3: redirect overrides load-use
        e_load = 1'b1; e_rd = 5'd6; e_wb = 1'b1; d_rs2 = 5'd6; d_use2 = 1'b1; e_redirect = 1'b1; #1;
        chk("redir_lu_ctl", 64'(ctl()), 64'b0000110);
        clear();

        // 4: memory wait holds a pending redirect, which lands when ready rises
        e_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memwait_%0d", i), 64'(ctl()), 64'b1111001);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("memready_ctl", 64'(ctl()), 64'b0000110);
        tick();
        clear();

        // 6: debug halt via 4-cycle drain, then resume
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; #1;
        chk("drain_halted", 64'(halted), 64'd0);
        chk("drain_ctl",    64'(ctl()), 64'b1000100);
        tick(); tick(); tick();
        chk("drain_4th_halted", 64'(halted), 64'd0);
        tick();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_ctl",    64'(ctl()), 64'b1111001);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0; #1;
        chk("resume_halted", 64'(halted), 64'd0);
        chk("resume_ctl",    64'(ctl()), 64'h0);

        // reset in the middle of a drain returns to RUN
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        reset_n = 1'b0; #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_drain_rst_halted", 64'(halted), 64'd0);
        chk("mid_drain_rst_ctl",    64'(ctl()), 64'h0);

        // 5: fault capture; later faults and resume ignored
        w_fault = 1'b1; w_pc = 32'h0000_0100;
        tick();
        w_fault = 1'b0; w_pc = 32'h0000_0200; #1;
        chk("fault_halted", 64'(halted), 64'd1);
        chk("fault_pc",     64'(fault_pc), 64'h100);
        chk("fault_valid",  64'(fault_valid), 64'd1);
        w_fault = 1'b1; w_pc = 32'h0000_0300;
        tick();
        w_fault = 1'b0; resume_req = 1'b1;
        tick();
        resume_req = 1'b0; #1;
        chk("fault_resume_halted", 64'(halted), 64'd1);
        chk("fault_pc_kept",       64'(fault_pc), 64'h100);
        reset_n = 1'b0; #1;
        chk("fault_rst_valid",  64'(fault_valid), 64'd0);
        chk("fault_rst_pc",     64'(fault_pc), 64'h0);
        chk("fault_rst_halted", 64'(halted), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
